// File: rtl/ext_mem_ctrl.sv
// ---------------------------------------------------------------------------
// ext_mem_ctrl
//
// Bridges the microprocessor_system external memory port to an off-chip
// synchronous SRAM. Each request moves one byte. The controller steps
// through IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> TURN.
// It drives the SRAM chip/write/output enables from registers and pulses
// ext_mem_ready for one cycle when an access completes.
//
// Optional feature (compile-time macro EXT_MEM_POST_WRITE_EN):
//   The controller gets a one-entry posted write buffer. A write accepted
//   in IDLE is acknowledged on the next cycle and then drains to the SRAM
//   in the background. Any request made while the buffer is full waits
//   until the drain finishes, which keeps read-after-write ordering.
//
// Handshake: the host holds ext_mem_cs plus read and/or write until it
//   sees ext_mem_ready. It must drop or replace the request no later than
//   the TURN cycle. A request still present in IDLE starts a new access.
//   Requests made while busy is high are ignored until the FSM returns to
//   IDLE.
//
// Parameters:
//   WAIT_STATES   extra ACCESS cycles per SRAM access (0..15)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ext_mem_addr      byte address from the host
//   ext_mem_wdata     host write data
//   ext_mem_rdata     registered read data, held until the next read
//   ext_mem_read      read request
//   ext_mem_write     write request
//   ext_mem_cs        request qualifier
//   ext_mem_ready     one-cycle completion pulse
//   sram_addr         SRAM address (stable through SETUP..ACCESS)
//   sram_wdata        SRAM write data
//   sram_rdata        SRAM read data
//   sram_ce/we/oe     SRAM strobes, active-high, registered
//   busy              FSM not in IDLE (or posted buffer full)
//   proto_err         sticky: read and write were requested together
//   state_dbg         current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module ext_mem_ctrl #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ext_mem_addr,
   input  logic [7:0]  ext_mem_wdata,
   output logic [7:0]  ext_mem_rdata,
   input  logic        ext_mem_read,
   input  logic        ext_mem_write,
   input  logic        ext_mem_cs,
   output logic        ext_mem_ready,
   output logic [15:0] sram_addr,
   output logic [7:0]  sram_wdata,
   input  logic [7:0]  sram_rdata,
   output logic        sram_ce,
   output logic        sram_we,
   output logic        sram_oe,
   output logic        busy,
   output logic        proto_err,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      DONE   = 3'd3,
      TURN   = 3'd4
   } state_t;

   // The counter reload value; the ACCESS phase lasts WAIT_LOAD+1 cycles.
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       is_read;
   logic       req;
   logic       last_cycle;

`ifdef EXT_MEM_POST_WRITE_EN
   // Set while an already acknowledged write is still draining to SRAM.
   logic       post_full;
`endif

   assign req       = ext_mem_cs & (ext_mem_read | ext_mem_write);
   assign state_dbg = state;

   // High in the final cycle that the SRAM strobes are active. Read data
   // is captured on the clock edge that ends this cycle.
   always_comb begin
      last_cycle = 1'b0;
      if (state == SETUP) begin
         last_cycle = (WAIT_STATES == 0);
      end else if (state == ACCESS) begin
         last_cycle = (wait_cnt == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= 4'd0;
         is_read       <= 1'b0;
         ext_mem_ready <= 1'b0;
         ext_mem_rdata <= 8'd0;
         sram_addr     <= 16'd0;
         sram_wdata    <= 8'd0;
         sram_ce       <= 1'b0;
         sram_we       <= 1'b0;
         sram_oe       <= 1'b0;
         busy          <= 1'b0;
         proto_err     <= 1'b0;
`ifdef EXT_MEM_POST_WRITE_EN
         post_full     <= 1'b0;
`endif
      end else begin
         ext_mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  state      <= SETUP;
                  sram_addr  <= ext_mem_addr;
                  sram_wdata <= ext_mem_wdata;
                  // A read+write collision is treated as a read.
                  is_read    <= ext_mem_read;
                  sram_ce    <= 1'b1;
                  sram_oe    <= ext_mem_read;
                  sram_we    <= ~ext_mem_read;
                  busy       <= 1'b1;
                  if (ext_mem_read & ext_mem_write) begin
                     proto_err <= 1'b1;
                  end
`ifdef EXT_MEM_POST_WRITE_EN
                  // Pure writes are acknowledged at once and drain later.
                  if (!ext_mem_read) begin
                     post_full     <= 1'b1;
                     ext_mem_ready <= 1'b1;
                  end
`endif
               end
            end

            SETUP, ACCESS: begin
               if (last_cycle) begin
                  state   <= DONE;
                  sram_ce <= 1'b0;
                  sram_we <= 1'b0;
                  sram_oe <= 1'b0;
                  if (is_read) begin
                     ext_mem_rdata <= sram_rdata;
                  end
`ifdef EXT_MEM_POST_WRITE_EN
                  // A draining write was already acknowledged.
                  ext_mem_ready <= ~post_full;
`else
                  ext_mem_ready <= 1'b1;
`endif
               end else if (state == SETUP) begin
                  wait_cnt <= WAIT_LOAD;
                  state    <= ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            DONE: begin
               state <= TURN;
            end

            TURN: begin
               state <= IDLE;
               busy  <= 1'b0;
`ifdef EXT_MEM_POST_WRITE_EN
               post_full <= 1'b0;
`endif
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
